// File: rtl/power_trigger_mavg.sv
// Moving-average |I|+|Q| power detector with hysteresis trigger, fall hold and initial skip.
// Optional peak tracker output enabled by defining POWER_TRIGGER_PEAK_EN.
module power_trigger_mavg #(
    parameter int         DATA_WIDTH    = 16,
    parameter int         WIN_LOG2      = 4,
    parameter logic [7:0] ADDR_THRES_HI = 8'd3,
    parameter logic [7:0] ADDR_THRES_LO = 8'd4,
    parameter logic [7:0] ADDR_HOLD     = 8'd5,
    parameter logic [7:0] ADDR_SKIP     = 8'd6
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [2*DATA_WIDTH-1:0] sample_in,
    input  logic                    sample_in_strobe,
    input  logic                    set_stb,
    input  logic [7:0]              set_addr,
    input  logic [31:0]             set_data,
    output logic [DATA_WIDTH:0]     power_out,
    output logic                    power_strobe,
    output logic                    trigger
`ifdef POWER_TRIGGER_PEAK_EN
    ,
    output logic [DATA_WIDTH:0]     peak_out
`endif
);

    localparam int MAG_W = DATA_WIDTH + 1;
    localparam int SUM_W = MAG_W + WIN_LOG2;
    localparam int DEPTH = 1 << WIN_LOG2;

    localparam logic [MAG_W-1:0]    MAG_ONE  = 1;
    localparam logic [WIN_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [WIN_LOG2:0]   FILL_ONE = 1;

    typedef enum logic [1:0] {S_SKIP, S_IDLE, S_PACKET} state_t;

    logic accept;
    assign accept = enable & sample_in_strobe;

    // Component magnitudes; the extra bit holds |most-negative| without saturation.
    logic [MAG_W-1:0] abs_comp [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_abs
            logic [MAG_W-1:0] comp_ext;
            assign comp_ext = {sample_in[(gi+1)*DATA_WIDTH-1],
                               sample_in[(gi+1)*DATA_WIDTH-1 -: DATA_WIDTH]};
            assign abs_comp[gi] = comp_ext[MAG_W-1] ? (~comp_ext + MAG_ONE) : comp_ext;
        end
    endgenerate

    logic [MAG_W-1:0] mag_next;
    assign mag_next = abs_comp[0] + abs_comp[1];

    logic [MAG_W-1:0]    mag_reg;
    logic                v1_reg;
    logic [WIN_LOG2-1:0] wr_ptr_reg;
    logic [WIN_LOG2:0]   fill_reg;
    logic [SUM_W-1:0]    sum_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mag_reg <= '0;
            v1_reg  <= 1'b0;
        end else begin
            v1_reg <= accept;
            if (accept) begin
                mag_reg <= mag_next;
            end
        end
    end

    // History RAM: the slot read for a new sample is the one it will overwrite,
    // one ahead of the pointer when the previous sample is being written this cycle.
    logic [MAG_W-1:0]    hist_mem [DEPTH];
    logic [MAG_W-1:0]    oldest_rd_reg;
    logic [WIN_LOG2-1:0] rd_addr;

    assign rd_addr = v1_reg ? (wr_ptr_reg + PTR_ONE) : wr_ptr_reg;

    always_ff @(posedge clock) begin
        if (v1_reg) begin
            hist_mem[wr_ptr_reg] <= mag_reg;
        end
        if (accept) begin
            oldest_rd_reg <= hist_mem[rd_addr];
        end
    end

    logic             window_full;
    logic [MAG_W-1:0] oldest;
    logic [SUM_W-1:0] sum_next;

    assign window_full = fill_reg[WIN_LOG2];
    assign oldest      = window_full ? oldest_rd_reg : '0;
    assign sum_next    = sum_reg + SUM_W'(mag_reg) - SUM_W'(oldest);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sum_reg      <= '0;
            wr_ptr_reg   <= '0;
            fill_reg     <= '0;
            power_out    <= '0;
            power_strobe <= 1'b0;
        end else begin
            power_strobe <= v1_reg;
            if (v1_reg) begin
                sum_reg    <= sum_next;
                power_out  <= sum_next[SUM_W-1:WIN_LOG2];
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                if (!window_full) begin
                    fill_reg <= fill_reg + FILL_ONE;
                end
            end
        end
    end

    logic [MAG_W-1:0] thres_hi_reg;
    logic [MAG_W-1:0] thres_lo_reg;
    logic [15:0]      hold_reg;
    logic [31:0]      skip_reg;
    logic             skip_wr;

    assign skip_wr = set_stb && (set_addr == ADDR_SKIP);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            thres_hi_reg <= MAG_W'(100);
            thres_lo_reg <= MAG_W'(80);
            hold_reg     <= 16'd80;
            skip_reg     <= 32'd5000000;
        end else if (set_stb) begin
            if (set_addr == ADDR_THRES_HI) thres_hi_reg <= set_data[DATA_WIDTH:0];
            if (set_addr == ADDR_THRES_LO) thres_lo_reg <= set_data[DATA_WIDTH:0];
            if (set_addr == ADDR_HOLD)     hold_reg     <= set_data[15:0];
            if (set_addr == ADDR_SKIP)     skip_reg     <= set_data;
        end
    end

    state_t      state_reg;
    logic [31:0] skip_cnt_reg;
    logic [15:0] low_cnt_reg;
    logic [16:0] low_inc;
    logic [16:0] hold_eff;

    assign low_inc  = {1'b0, low_cnt_reg} + 17'd1;
    assign hold_eff = (hold_reg == 16'd0) ? 17'd1 : {1'b0, hold_reg};

    // A skip write restarts the skip phase and wins over any evaluation in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_SKIP;
            skip_cnt_reg <= '0;
            low_cnt_reg  <= '0;
            trigger      <= 1'b0;
`ifdef POWER_TRIGGER_PEAK_EN
            peak_out     <= '0;
`endif
        end else if (skip_wr) begin
            trigger      <= 1'b0;
            skip_cnt_reg <= '0;
            state_reg    <= S_SKIP;
        end else if (power_strobe) begin
            case (state_reg)
                S_SKIP: begin
                    if (skip_cnt_reg >= skip_reg) begin
                        state_reg <= S_IDLE;
                    end else begin
                        skip_cnt_reg <= skip_cnt_reg + 32'd1;
                    end
                end
                S_IDLE: begin
                    if (power_out > thres_hi_reg) begin
                        trigger     <= 1'b1;
                        low_cnt_reg <= '0;
                        state_reg   <= S_PACKET;
`ifdef POWER_TRIGGER_PEAK_EN
                        peak_out    <= power_out;
`endif
                    end
                end
                S_PACKET: begin
`ifdef POWER_TRIGGER_PEAK_EN
                    if (power_out > peak_out) begin
                        peak_out <= power_out;
                    end
`endif
                    if (power_out < thres_lo_reg) begin
                        if (low_inc >= hold_eff) begin
                            trigger     <= 1'b0;
                            low_cnt_reg <= '0;
                            state_reg   <= S_IDLE;
                        end else begin
                            low_cnt_reg <= low_inc[15:0];
                        end
                    end else begin
                        low_cnt_reg <= '0;
                    end
                end
                default: state_reg <= S_SKIP;
            endcase
        end
    end

endmodule

// File: tb/tb_power_trigger_mavg.sv
// Bench for power_trigger_mavg: vector table, directed corner sequences and
// randomized traffic checked every cycle against a window/hysteresis reference model.
module tb_power_trigger_mavg;

    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [2*DW-1:0] sample_in = '0;
    logic          sample_in_strobe = 1'b0;
    logic          set_stb = 1'b0;
    logic [7:0]    set_addr = '0;
    logic [31:0]   set_data = '0;
    logic [DW:0]   power_out;
    logic          power_strobe;
    logic          trigger;
`ifdef POWER_TRIGGER_PEAK_EN
    logic [DW:0]   peak_out;
`endif

    always #5 clock = ~clock;

    power_trigger_mavg dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .enable           (enable),
        .sample_in        (sample_in),
        .sample_in_strobe (sample_in_strobe),
        .set_stb          (set_stb),
        .set_addr         (set_addr),
        .set_data         (set_data),
        .power_out        (power_out),
        .power_strobe     (power_strobe),
`ifdef POWER_TRIGGER_PEAK_EN
        .peak_out         (peak_out),
`endif
        .trigger          (trigger)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: window as a queue of the last 16 magnitudes, trigger rules applied per strobe.
    int     m_mags[$];
    bit     m_pend_valid, m_ps, m_trig;
    int     m_pend_pow, m_pow, m_state, m_low_cnt, m_peak, m_sum;
    longint m_hi, m_lo, m_hold, m_skip, m_skip_cnt;

    function automatic int mag_of(input logic [31:0] s);
        int i;
        int q;
        i = int'($signed(s[31:16]));
        q = int'($signed(s[15:0]));
        return (i < 0 ? -i : i) + (q < 0 ? -q : q);
    endfunction

    function automatic void model_reset();
        m_mags.delete();
        m_pend_valid = 0; m_ps = 0; m_trig = 0;
        m_pend_pow = 0; m_pow = 0; m_state = 0; m_low_cnt = 0; m_peak = 0;
        m_hi = 100; m_lo = 80; m_hold = 80; m_skip = 5000000; m_skip_cnt = 0;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            if (set_stb && set_addr == 8'd6) begin
                m_trig = 0; m_skip_cnt = 0; m_state = 0;
            end else if (m_ps) begin
                if (m_state == 0) begin
                    if (m_skip_cnt >= m_skip) m_state = 1;
                    else m_skip_cnt++;
                end else if (m_state == 1) begin
                    if (m_pow > m_hi) begin
                        m_trig = 1; m_low_cnt = 0; m_state = 2; m_peak = m_pow;
                    end
                end else begin
                    if (m_pow > m_peak) m_peak = m_pow;
                    if (m_pow < m_lo) begin
                        m_low_cnt++;
                        if (m_low_cnt >= ((m_hold == 0) ? 1 : m_hold)) begin
                            m_trig = 0; m_state = 1;
                        end
                    end else begin
                        m_low_cnt = 0;
                    end
                end
            end
            if (set_stb) begin
                case (set_addr)
                    8'd3: m_hi = longint'(set_data[DW:0]);
                    8'd4: m_lo = longint'(set_data[DW:0]);
                    8'd5: m_hold = longint'(set_data[15:0]);
                    8'd6: m_skip = longint'(set_data);
                    default: ;
                endcase
            end
            m_ps = m_pend_valid;
            if (m_pend_valid) m_pow = m_pend_pow;
            m_pend_valid = enable && sample_in_strobe;
            if (m_pend_valid) begin
                m_mags.push_back(mag_of(sample_in));
                if (m_mags.size() > 16) void'(m_mags.pop_front());
                m_sum = 0;
                foreach (m_mags[k]) m_sum += m_mags[k];
                m_pend_pow = m_sum / 16;
            end
        end
    end

    always @(negedge clock) begin
        check("power_strobe", power_strobe, m_ps);
        check("power_out", power_out, m_pow);
        check("trigger", trigger, m_trig);
`ifdef POWER_TRIGGER_PEAK_EN
        check("peak_out", peak_out, m_peak);
`endif
    end

    // Event logs: power per strobe, trigger seen right after each strobe, and strobe cycle.
    int cyc = 0;
    int pw_log[$];
    int tr_log[$];
    int ps_cyc_log[$];
    bit prev_ps = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (prev_ps) tr_log.push_back(int'(trigger));
        if (power_strobe) begin
            pw_log.push_back(int'(power_out));
            ps_cyc_log.push_back(cyc);
        end
        prev_ps = power_strobe;
    end

    function automatic int pw_at(input int k);
        return (k < pw_log.size()) ? pw_log[k] : -1;
    endfunction

    function automatic int tr_at(input int k);
        return (k < tr_log.size()) ? tr_log[k] : -1;
    endfunction

    function automatic int cyc_at(input int k);
        return (k < ps_cyc_log.size()) ? ps_cyc_log[k] : -1;
    endfunction

    task automatic clear_logs();
        pw_log.delete();
        tr_log.delete();
        ps_cyc_log.delete();
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input int i, input int q);
        sample_in        = {i[15:0], q[15:0]};
        enable           = 1'b1;
        sample_in_strobe = 1'b1;
        tick();
        sample_in_strobe = 1'b0;
    endtask

    task automatic send_n(input int n, input int i, input int q);
        repeat (n) send(i, q);
    endtask

    task automatic write(input int addr, input int data);
        set_stb  = 1'b1;
        set_addr = addr[7:0];
        set_data = data;
        tick();
        set_stb  = 1'b0;
    endtask

    typedef struct {
        int i;
        int q;
        int exp_pow;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int c0;
        int ones;
        int loud;
        int amp;
        int ri;
        int rq;
        vecs[0] = '{256, 256, 512};
        vecs[1] = '{32767, 0, 32767};
        vecs[2] = '{-32768, -32768, 65536};
        vecs[3] = '{-1, 1, 2};
        vecs[4] = '{0, 0, 0};
        vecs[5] = '{-5, 7, 12};
        vecs[6] = '{-32768, 32767, 65535};

        model_reset();
        idle(3);
        check("reset_power_out", power_out, 0);
        check("reset_trigger", trigger, 0);
        check("reset_power_strobe", power_strobe, 0);
        reset_n = 1'b1;
        idle(2);

        // Skip phase and window ramp
        write(6, 10);
        clear_logs();
        c0 = cyc;
        send_n(16, 256, 256);
        idle(4);
        $display("seq skip_ramp: %0d power strobes logged", pw_log.size());
        check("ramp_strobe_count", pw_log.size(), 16);
        for (int k = 0; k < 16; k++) check("ramp_power", pw_at(k), 32 * (k + 1));
        check("first_strobe_lag", cyc_at(0) - c0, 2);
        check("last_strobe_lag", cyc_at(15) - c0, 17);
        ones = 0;
        for (int k = 0; k < 11; k++) if (tr_at(k) != 0) ones++;
        check("trigger_during_skip", ones, 0);
        check("trigger_after_skip", tr_at(11), 1);

        // Steady-state magnitudes
        for (int v = 0; v < 7; v++) begin
            send_n(16, vecs[v].i, vecs[v].q);
            idle(3);
            $display("vec %0d: I=%0d Q=%0d power_out=%0d", v, vecs[v].i, vecs[v].q, power_out);
            check("table_power", power_out, vecs[v].exp_pow);
        end

        // Rise
        write(3, 100);
        write(4, 80);
        write(5, 3);
        write(6, 0);
        send_n(24, 0, 0);
        idle(4);
        check("pre_rise_idle", trigger, 0);
        clear_logs();
        send(32767, 0);
        idle(4);
        $display("seq rise: power=%0d trigger=%0d", pw_at(0), tr_at(0));
        check("rise_power", pw_at(0), 2047);
        check("rise_trigger", tr_at(0), 1);

        // Hysteresis band and hold
        clear_logs();
        send_n(40, 85, 0);
        idle(4);
        ones = 0;
        foreach (tr_log[k]) if (tr_log[k] == 1) ones++;
        check("hyst_strobes", tr_log.size(), 40);
        check("hyst_trigger_held", ones, 40);
        clear_logs();
        send_n(3, 0, 0);
        idle(4);
        $display("seq hold: powers %0d %0d %0d triggers %0d %0d %0d",
                 pw_at(0), pw_at(1), pw_at(2), tr_at(0), tr_at(1), tr_at(2));
        check("hold_first_low_power", pw_at(0), 79);
        check("hold_low1", tr_at(0), 1);
        check("hold_low2", tr_at(1), 1);
        check("hold_low3_fall", tr_at(2), 0);

        // Skip write coincident with a power strobe mid-packet
        send_n(4, 32767, 0);
        idle(3);
        check("packet_before_skip", trigger, 1);
        send(32767, 0);
        tick();
        set_stb  = 1'b1;
        set_addr = 8'd6;
        set_data = 32'd4;
        @(negedge clock);
        check("skip_write_on_strobe", power_strobe, 1);
        @(posedge clock);
        #1;
        set_stb = 1'b0;
        @(negedge clock);
        check("skip_write_clears_trigger", trigger, 0);
        tick();
        clear_logs();
        send_n(6, 32767, 0);
        idle(4);
        ones = 0;
        for (int k = 0; k < 5; k++) if (tr_at(k) != 0) ones++;
        $display("seq mid_skip: retrigger flag after 6th strobe=%0d", tr_at(5));
        check("retrigger_blocked", ones, 0);
        check("retrigger_6th", tr_at(5), 1);

        // Asynchronous reset mid-packet
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_trigger", trigger, 0);
        check("async_reset_power", power_out, 0);
        tick();
        reset_n = 1'b1;
        idle(2);

`ifdef POWER_TRIGGER_PEAK_EN
        write(5, 2);
        write(6, 0);
        send_n(16, 500, 0);
        send_n(16, 900, 0);
        send_n(16, 700, 0);
        idle(4);
        check("peak_in_packet", peak_out, 900);
        send_n(20, 0, 0);
        idle(4);
        check("peak_after_fall_trigger", trigger, 0);
        check("peak_held", peak_out, 900);
        send(32767, 0);
        idle(4);
        check("peak_new_packet", peak_out, 2047);
        $display("seq peak: peak_out=%0d", peak_out);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        idle(2);
`endif

        // Randomized traffic
        write(5, 2);
        write(6, 1);
        loud = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) loud = int'($urandom_range(0, 1));
            enable           = ($urandom_range(0, 7) != 0);
            sample_in_strobe = ($urandom_range(0, 3) != 0);
            amp = loud ? 32768 : 60;
            ri = int'($urandom_range(0, 2 * amp)) - amp;
            rq = int'($urandom_range(0, 2 * amp)) - amp;
            if (ri > 32767) ri = 32767;
            if (rq > 32767) rq = 32767;
            sample_in = {ri[15:0], rq[15:0]};
            set_stb = ($urandom_range(0, 99) == 0);
            set_addr = 8'($urandom_range(2, 7));
            case (set_addr)
                8'd3, 8'd4: set_data = $urandom_range(20, 3000);
                8'd5:       set_data = $urandom_range(0, 4);
                8'd6:       set_data = $urandom_range(0, 3);
                default:    set_data = $urandom;
            endcase
            tick();
        end
        set_stb = 1'b0;
        sample_in_strobe = 1'b0;
        idle(5);
        $display("seq random: 3000 cycles done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/power_trigger_mavg.md
Name: power_trigger_mavg

Overview:
Parametrised successor power detector for the OFDM receive front end. It computes a moving-average magnitude |I|+|Q| over a 2^WIN_LOG2-sample window. It asserts trigger using hysteresis: a rise threshold, a fall threshold and a fall hold count. Sits between the sample source and the sync/detection chain; configured over the standard set_stb/set_addr/set_data settings bus.

Parameters:
DATA_WIDTH, 16, bits per I and Q component (two's complement)
WIN_LOG2, 4, log2 of averaging window depth (window = 16 samples)
ADDR_THRES_HI, 8'd3, settings address of rise threshold
ADDR_THRES_LO, 8'd4, settings address of fall threshold
ADDR_HOLD, 8'd5, settings address of fall hold count
ADDR_SKIP, 8'd6, settings address of initial skip count

Ports:
clock  in  1  single clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  qualifies sample_in_strobe
sample_in  in  2*DATA_WIDTH  {I, Q}; I in upper half
sample_in_strobe  in  1  sample valid
set_stb  in  1  settings write strobe
set_addr  in  8  settings address
set_data  in  32  settings data
power_out  out  DATA_WIDTH+1  window average magnitude
power_strobe  out  1  power_out valid, one-cycle pulse
trigger  out  1  packet-present flag

Behaviour:
- Reset is asynchronous and active-low: clock, reset_n. On reset_n=0:
  - Outputs: trigger=0, power_out=0, power_strobe=0.
  - State S_SKIP; all counters 0; fill count 0.
  - Settings: thres_hi=100, thres_lo=80, hold=80, skip=5000000.
- Settings registers:
  - Written on set_stb when set_addr matches.
  - Thresholds take set_data[DATA_WIDTH:0]; hold takes [15:0]; skip takes [31:0].
  - Writes take effect at the next power_strobe.
- Pipeline advances only when enable & sample_in_strobe.
  - Stage 1, registered: mag = |I|+|Q|, DATA_WIDTH+1 bits unsigned. |most-negative| = 2^(DATA_WIDTH-1); no saturation needed.
  - Stage 2: sum += mag - oldest. Sum width is DATA_WIDTH+1+WIN_LOG2; it never wraps.
  - History buffer: circular, depth 2^WIN_LOG2.
  - While fill count < depth, oldest is taken as 0. The buffer needs no reset clear.
- Output timing:
  - power_out = sum >> WIN_LOG2.
  - power_strobe pulses exactly 2 cycles after the accepted strobe.
  - Back-to-back strobes every cycle are supported at full throughput.
- enable low: strobes are ignored. A stage-2 update already in flight still completes and still pulses power_strobe.
- State machine (evaluated only on power_strobe):
  - S_SKIP: if skip_cnt >= skip, go to S_IDLE; else skip_cnt++. No trigger evaluation. skip=0 exits on the first power_strobe.
  - S_IDLE: if power_out > thres_hi: trigger<=1, low_cnt<=0, go to S_PACKET.
  - S_PACKET:
    - If power_out < thres_lo: low_cnt++.
    - When low_cnt+1 >= max(hold,1): trigger<=0, go to S_IDLE.
    - If power_out >= thres_lo: low_cnt<=0.
- Skip-register write in any state (same cycle priority over state logic):
  - trigger<=0, skip_cnt<=0, state S_SKIP.
  - Window contents are retained.
- Simultaneous set_stb (skip write) and power_strobe: the write wins; that sample is not evaluated.
- thres_lo > thres_hi is permitted. Hysteresis then degenerates; behaviour is still exactly as the rules above.

Optional Feature:
Macro POWER_TRIGGER_PEAK_EN.
- Defined: adds output peak_out [DATA_WIDTH:0].
  - Tracks max power_out while in S_PACKET.
  - Cleared to 0 on entry to S_PACKET, then loaded with the triggering power_out.
  - Holds its value after trigger falls until the next packet.
  - Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset/skip: skip=10, constant I=Q=0x0100, strobes every cycle. Required response:
  - trigger stays 0 through the 11th power_strobe.
  - power_strobe lags each strobe by 2 cycles.
  - power_out ramps 32,64,…,512 over 16 samples.
- Rise: skip=0, thres_hi=100, thres_lo=80, hold=3. Drive |I|+|Q|=0 for 16 samples, then 0x7FFF+0 (32767). Required response: trigger rises on the first power_strobe with power_out=2047 (>100).
- Hysteresis/hold: after rise, drive mag=85 (between lo and hi) indefinitely. Required response:
  - trigger stays 1.
  - Then drive mag=0: trigger falls exactly when the average first drops below 80, plus 2 more low power_strobes (3 total).
- Extreme value: I=Q=-32768 for 16 samples. Required response: mag=65536, power_out=65536 (17 bits), no wrap.
- Mid-packet skip write: while trigger=1, write skip=4 coincident with a power_strobe. Required response:
  - trigger=0 next cycle, state S_SKIP.
  - Re-trigger possible only after 5 further power_strobes.
  - Async reset_n pulse mid-packet clears trigger immediately, without a clock edge.
- POWER_TRIGGER_PEAK_EN: packet averages 500→900→700. Required response: peak_out=900, held after trigger falls, reset to new trigger value on the next packet.
